// File: rtl/tx_frame_buf_pkg.sv
// tx_frame_buf_pkg: state encodings and video component offsets shared by the frame buffer
package tx_frame_buf_pkg;
  typedef enum logic [1:0] {W_IDLE, W_CAP, W_DROP} w_st_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_st_e;
  typedef enum logic [1:0] {FREE, FILLING, FULL, READING} buf_st_e;
  localparam int R_OFF = 20;
  localparam int G_OFF = 10;
  localparam int B_OFF = 0;
endpackage

// File: rtl/tx_frame_buf_if.sv
// tx_frame_buf_if: video input stream, capture enable and radio transmit handshake of tx_frame_buf
interface tx_frame_buf_if #(parameter int AXI_W = 32, parameter int PIX_W = 12, parameter int ADDR_W = 17);
  logic [AXI_W-1:0] s_axis_video_tdata;
  logic s_axis_video_tvalid;
  logic s_axis_video_tuser;
  logic s_axis_video_tlast;
  logic s_axis_video_tready;
  logic cap_en;
  logic tx_en;
  logic [PIX_W-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_frame;
  logic tx_last;
  logic [ADDR_W-1:0] tx_add;
  logic tx_buf;
  logic tx_abort;
  modport master (
    output s_axis_video_tdata, s_axis_video_tvalid, s_axis_video_tuser, s_axis_video_tlast, cap_en, tx_ready, tx_abort,
    input s_axis_video_tready, tx_en, tx_data, tx_valid, tx_frame, tx_last, tx_add, tx_buf
  );
  modport slave (
    input s_axis_video_tdata, s_axis_video_tvalid, s_axis_video_tuser, s_axis_video_tlast, cap_en, tx_ready, tx_abort,
    output s_axis_video_tready, tx_en, tx_data, tx_valid, tx_frame, tx_last, tx_add, tx_buf
  );
endinterface

// File: rtl/tx_fb_ram.sv
// tx_fb_ram: ping-pong frame store addressed by {buf, addr}, one write port and one registered read port
module tx_fb_ram #(parameter int W = 12, parameter int AW = 4) (
  input logic Cclk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [W-1:0] wdata,
  input logic re,
  input logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge Cclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/tx_frame_buf.sv
// tx_frame_buf: decimating two-frame video store streamed to the radio; drop_cnt port added by TX_FRAME_BUF_DROP_CNT_EN
module tx_frame_buf
  import tx_frame_buf_pkg::*;
#(
  parameter int AXI_W = 32,
  parameter int PIX_W = 12,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int DEC = 2,
  parameter int DEPTH = (H_ACT / DEC) * (V_ACT / DEC),
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic Cclk,
  input logic rst,
`ifdef TX_FRAME_BUF_DROP_CNT_EN
  output logic [15:0] drop_cnt,
`endif
  tx_frame_buf_if.slave bus
);
  localparam int C = PIX_W / 3;
  localparam int HD = H_ACT / DEC;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  w_st_e w_st, w_nx;
  r_st_e r_st, r_nx;
  buf_st_e bst [2];
  buf_st_e bst_nx [2];
  logic [31:0] x, y, cx, cy, wa;
  logic beat, sof, eof, win, hs, rd_free, start, we, wb, pick;
  logic w_buf, w_buf_nx, last_done, last_nx, tx_buf, buf_nx;
  logic [1:0] free, full;
  logic [ADDR_W-1:0] tx_add, add_nx;
  logic [PIX_W-1:0] pix, rdata;
  logic unused_ok;
  assign beat = bus.s_axis_video_tvalid;
  assign sof = beat && bus.s_axis_video_tuser;
  assign cx = sof ? '0 : x;
  assign cy = sof ? '0 : y;
  assign eof = beat && bus.s_axis_video_tlast && cy == V_ACT - 1;
  assign win = cx < H_ACT && cy < V_ACT && cx % DEC == 0 && cy % DEC == 0;
  assign wa = (cy / DEC) * HD + cx / DEC;
  assign pix = {bus.s_axis_video_tdata[R_OFF+9 -: C], bus.s_axis_video_tdata[G_OFF+9 -: C], bus.s_axis_video_tdata[B_OFF+9 -: C]};
  assign hs = bus.tx_valid && bus.tx_ready;
  assign rd_free = r_st != R_IDLE && (bus.tx_abort || hs && bus.tx_last);
  assign free = {bst[1] == FREE || rd_free && tx_buf, bst[0] == FREE || rd_free && !tx_buf};
  assign full = {bst[1] == FULL, bst[0] == FULL};
  assign pick = &full ? !last_done : full[1];
  assign start = sof && w_st != W_CAP && bus.cap_en && |free;
  assign wb = start ? !free[0] : w_buf;
  assign we = beat && win && (start || w_st == W_CAP);
  assign unused_ok = ^{bus.s_axis_video_tdata, wa};
  always_comb begin
    w_nx = w_st;
    w_buf_nx = w_buf;
    last_nx = last_done;
    r_nx = r_st;
    buf_nx = tx_buf;
    add_nx = tx_add;
    bst_nx = bst;
    if (rd_free) begin
      r_nx = R_IDLE;
      bst_nx[tx_buf] = FREE;
    end else if (r_st == R_IDLE && |full && !bus.tx_abort) begin
      r_nx = R_FETCH;
      buf_nx = pick;
      add_nx = '0;
      bst_nx[pick] = READING;
    end else if (r_st == R_FETCH) r_nx = R_SEND;
    else if (hs) begin
      r_nx = R_FETCH;
      add_nx = tx_add + 1'b1;
    end
    if (start) begin
      w_nx = W_CAP;
      w_buf_nx = wb;
      bst_nx[wb] = FILLING;
    end else if (sof && w_st != W_CAP) w_nx = W_DROP;
    else if (eof && !sof) begin
      w_nx = W_IDLE;
      if (w_st == W_CAP) begin
        bst_nx[w_buf] = FULL;
        last_nx = w_buf;
      end
    end
  end
  always_ff @(posedge Cclk or posedge rst)
    if (rst) begin
      w_st <= W_IDLE;
      r_st <= R_IDLE;
      bst <= '{FREE, FREE};
      w_buf <= 1'b0;
      last_done <= 1'b0;
      tx_buf <= 1'b0;
      tx_add <= '0;
      x <= '0;
      y <= '0;
    end else begin
      w_st <= w_nx;
      r_st <= r_nx;
      bst <= bst_nx;
      w_buf <= w_buf_nx;
      last_done <= last_nx;
      tx_buf <= buf_nx;
      tx_add <= add_nx;
      if (beat) begin
        x <= bus.s_axis_video_tlast ? '0 : cx + 1;
        y <= bus.s_axis_video_tlast ? cy + 1 : cy;
      end
    end
`ifdef TX_FRAME_BUF_DROP_CNT_EN
  always_ff @(posedge Cclk or posedge rst)
    if (rst) drop_cnt <= '0;
    else if (sof && w_st != W_CAP && bus.cap_en && !(|free) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
  tx_fb_ram #(.W(PIX_W), .AW(ADDR_W + 1)) u_ram (
    .Cclk(Cclk),
    .we(we),
    .waddr({wb, wa[ADDR_W-1:0]}),
    .wdata(pix),
    .re(r_st == R_FETCH),
    .raddr({tx_buf, tx_add}),
    .rdata(rdata)
  );
  assign bus.s_axis_video_tready = 1'b1;
  assign bus.tx_valid = r_st == R_SEND;
  assign bus.tx_en = r_st != R_IDLE;
  assign bus.tx_data = bus.tx_valid ? rdata : '0;
  assign bus.tx_add = tx_add;
  assign bus.tx_buf = tx_buf;
  assign bus.tx_frame = bus.tx_en && tx_add == '0;
  assign bus.tx_last = bus.tx_en && tx_add == LAST;
endmodule
